// File: rtl/window_stream_3x3_pkg.sv
// Shared constants for the 3x3 window stream and the blocks around it:
// tap count, tap order inside the packed window word, default geometry.
package window_stream_3x3_pkg;

  localparam int WIN_TAPS = 9;

  // Tap index inside m_win; tap k occupies bits [k*DW +: DW].
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int P5 = 4;
  localparam int P6 = 5;
  localparam int P7 = 6;
  localparam int P8 = 7;
  localparam int P9 = 8;

  localparam int DEF_DW    = 8;
  localparam int DEF_IMG_W = 258;
  localparam int DEF_IMG_H = 34;

  // Bit offset of a tap in a packed window word.
  function automatic int tap_lsb(input int tap, input int dw);
    return tap * dw;
  endfunction

endpackage

// File: rtl/window_stream_3x3_line_buffer.sv
// One image line of storage. Read is combinational on the same address that
// is written, so the old pixel at this column comes out in the accept cycle
// and can be forwarded into the next buffer of the cascade.
module window_stream_3x3_line_buffer #(
  parameter int DW    = 8,
  parameter int DEPTH = 258,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // Write the new pixel for this column; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  assign dout = mem[addr];

endmodule

// File: rtl/window_stream_3x3.sv
// Streaming 3x3 window generator. Raster pixels in, one packed interior
// window out per accepted pixel at row>=2, col>=2, one cycle later.
module window_stream_3x3
  import window_stream_3x3_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [DW-1:0]          s_data,
  input  logic                   s_sof,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIN_TAPS*DW-1:0] m_win,
  output logic                   m_last,
  output logic                   err_sof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Column history per window row: c1 = one column back, c2 = two back.
  logic [DW-1:0] top_c1_q, top_c1_d, top_c2_q, top_c2_d;
  logic [DW-1:0] mid_c1_q, mid_c1_d, mid_c2_q, mid_c2_d;
  logic [DW-1:0] bot_c1_q, bot_c1_d, bot_c2_q, bot_c2_d;

  logic                   m_valid_q, m_valid_d;
  logic [WIN_TAPS*DW-1:0] m_win_q, m_win_d;
  logic                   m_last_q, m_last_d;
  logic                   err_sof_q, err_sof_d;

  logic                   accept;
  logic                   restart;
  logic [CW-1:0]          pos_col;
  logic [RW-1:0]          pos_row;
  logic                   win_fire;
  logic                   frame_end;
  logic [DW-1:0]          lb1_rd;
  logic [DW-1:0]          lb2_rd;
  logic [WIN_TAPS*DW-1:0] win_now;

  assign s_ready  = !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;

  // A misplaced start-of-frame re-homes this pixel to (0,0).
  assign restart  = s_sof && ((col_q != '0) || (row_q != '0));
  assign pos_col  = restart ? '0 : col_q;
  assign pos_row  = restart ? '0 : row_q;

  assign win_fire  = accept && (pos_row >= RW'(2)) && (pos_col >= CW'(2));
  assign frame_end = (pos_col == COL_MAX) && (pos_row == ROW_MAX);

  // lb1 holds the line above, lb2 the line two above; lb2 is fed from lb1's
  // old value so each line moves down one buffer as it is overwritten.
  window_stream_3x3_line_buffer #(
    .DW(DW), .DEPTH(IMG_W), .AW(CW)
  ) u_lb1 (
    .clk(clk), .we(accept), .addr(pos_col), .din(s_data), .dout(lb1_rd)
  );

  window_stream_3x3_line_buffer #(
    .DW(DW), .DEPTH(IMG_W), .AW(CW)
  ) u_lb2 (
    .clk(clk), .we(accept), .addr(pos_col), .din(lb1_rd), .dout(lb2_rd)
  );

  // Raster position: advance on accept, wrapping at line and frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (pos_col == COL_MAX) begin
        col_d = '0;
        row_d = (pos_row == ROW_MAX) ? '0 : pos_row + 1'b1;
      end else begin
        col_d = pos_col + 1'b1;
        row_d = pos_row;
      end
    end
  end

  // Horizontal shift; history is cleared at column 0 so windows never wrap.
  always_comb begin
    top_c1_d = top_c1_q;
    top_c2_d = top_c2_q;
    mid_c1_d = mid_c1_q;
    mid_c2_d = mid_c2_q;
    bot_c1_d = bot_c1_q;
    bot_c2_d = bot_c2_q;
    if (accept) begin
      top_c1_d = lb2_rd;
      mid_c1_d = lb1_rd;
      bot_c1_d = s_data;
      if (pos_col == '0) begin
        top_c2_d = '0;
        mid_c2_d = '0;
        bot_c2_d = '0;
      end else begin
        top_c2_d = top_c1_q;
        mid_c2_d = mid_c1_q;
        bot_c2_d = bot_c1_q;
      end
    end
  end

  // Assemble the window whose bottom-right pixel is being accepted now.
  always_comb begin
    win_now = '0;
    win_now[P1*DW +: DW] = top_c2_q;
    win_now[P2*DW +: DW] = top_c1_q;
    win_now[P3*DW +: DW] = lb2_rd;
    win_now[P4*DW +: DW] = mid_c2_q;
    win_now[P5*DW +: DW] = mid_c1_q;
    win_now[P6*DW +: DW] = lb1_rd;
    win_now[P7*DW +: DW] = bot_c2_q;
    win_now[P8*DW +: DW] = bot_c1_q;
    win_now[P9*DW +: DW] = s_data;
  end

  // Single output register: load on a new window, drain on m_ready, else hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_win_d   = m_win_q;
    m_last_d  = m_last_q;
    err_sof_d = accept && restart;
    if (win_fire) begin
      m_valid_d = 1'b1;
      m_win_d   = win_now;
      m_last_d  = frame_end;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      top_c1_q  <= '0;
      top_c2_q  <= '0;
      mid_c1_q  <= '0;
      mid_c2_q  <= '0;
      bot_c1_q  <= '0;
      bot_c2_q  <= '0;
      m_valid_q <= 1'b0;
      m_win_q   <= '0;
      m_last_q  <= 1'b0;
      err_sof_q <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      top_c1_q  <= top_c1_d;
      top_c2_q  <= top_c2_d;
      mid_c1_q  <= mid_c1_d;
      mid_c2_q  <= mid_c2_d;
      bot_c1_q  <= bot_c1_d;
      bot_c2_q  <= bot_c2_d;
      m_valid_q <= m_valid_d;
      m_win_q   <= m_win_d;
      m_last_q  <= m_last_d;
      err_sof_q <= err_sof_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_win   = m_win_q;
  assign m_last  = m_last_q;
  assign err_sof = err_sof_q;

endmodule
